// File: rtl/board_pkg.sv
// Shared definitions for the board field writer and the board field selectors.
// Cell p of a packed board lives at bits [field_off(p, cell_w) +: cell_w].
package board_pkg;

   localparam int NCELL = 16;
   localparam int POS_W = 4;

   typedef enum logic {
      IDLE  = 1'b0,
      CLEAR = 1'b1
   } state_t;

   function automatic int field_off(input logic [POS_W-1:0] pos, input int cell_w);
      return int'(pos) * cell_w;
   endfunction

endpackage

// File: rtl/board_zero_counter.sv
// Counts the zero-valued cells of a packed board; feeds tile spawning.
module board_zero_counter
   import board_pkg::*;
#(
   parameter  int CELL_W  = 4,
   localparam int BOARD_W = NCELL * CELL_W
) (
   input  logic [BOARD_W-1:0] board,
   output logic [4:0]         zero_cnt
);

   always_comb begin
      zero_cnt = '0;
      for (int i = 0; i < NCELL; i++) begin
         if (board[i*CELL_W +: CELL_W] == '0) begin
            zero_cnt = zero_cnt + 5'd1;
         end
      end
   end

endmodule

// File: rtl/board_field_writer.sv
// Registered 16-cell game board with a single-cell write port, one-cycle whole-board load
// and a sequenced 16-cycle clear that zeroes one cell per cycle.
module board_field_writer
   import board_pkg::*;
#(
   parameter  int CELL_W  = 4,
   localparam int BOARD_W = NCELL * CELL_W
) (
   input  logic               clk,
   input  logic               rst,
   // Write handshake: a write is taken at the edge where wr_valid && wr_ready.
   // wr_ready depends on registered state only, so a source may hold wr_valid across busy.
   input  logic               wr_valid,
   output logic               wr_ready,
   input  logic [POS_W-1:0]   wr_pos,
   input  logic [CELL_W-1:0]  wr_val,
   input  logic               ld_valid,
   input  logic [BOARD_W-1:0] ld_board,
   input  logic               clr_start,
   output logic               busy,
   output logic               clr_done,
   output logic [BOARD_W-1:0] board_out,
   output logic [4:0]         empty_cnt
);

   state_t             state;
   logic [POS_W-1:0]   clr_cnt;
   logic [BOARD_W-1:0] nxt_board;

   // Load forms the base, then a same-cycle write overrides one cell of it.
   always_comb begin
      nxt_board = ld_valid ? ld_board : board_out;
      if (wr_valid) begin
         nxt_board[field_off(wr_pos, CELL_W) +: CELL_W] = wr_val;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         clr_cnt   <= '0;
         clr_done  <= 1'b0;
         board_out <= '0;
      end else begin
         clr_done <= 1'b0;
         case (state)
            IDLE: begin
               board_out <= nxt_board;
               if (clr_start) begin
                  state   <= CLEAR;
                  clr_cnt <= '0;
               end
            end
            CLEAR: begin
               board_out[field_off(clr_cnt, CELL_W) +: CELL_W] <= '0;
               clr_cnt <= clr_cnt + 1'b1;
               if (clr_cnt == POS_W'(NCELL - 1)) begin
                  state    <= IDLE;
                  clr_done <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign wr_ready = (state == IDLE);
   assign busy     = (state == CLEAR);

   board_zero_counter #(.CELL_W(CELL_W)) u_zero_counter (
      .board    (board_out),
      .zero_cnt (empty_cnt)
   );

endmodule

// File: tb/tb_board_field_writer.sv
// Bench for board_field_writer: directed scenarios plus random traffic against a cell-array model.
module tb_board_field_writer;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   always #5 clk = ~clk;

   // CELL_W=4 instance
   logic        rst, wr_valid, ld_valid, clr_start;
   logic [3:0]  wr_pos, wr_val;
   logic [63:0] ld_board;
   logic        wr_ready, busy, clr_done;
   logic [63:0] board_out;
   logic [4:0]  empty_cnt;

   // CELL_W=5 instance
   logic        rst5, wr_valid5, ld_valid5, clr_start5;
   logic [3:0]  wr_pos5;
   logic [4:0]  wr_val5;
   logic [79:0] ld_board5;
   logic        wr_ready5, busy5, clr_done5;
   logic [79:0] board_out5;
   logic [4:0]  empty_cnt5;

   board_field_writer #(.CELL_W(4)) dut (
      .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_pos(wr_pos),
      .wr_val(wr_val), .ld_valid(ld_valid), .ld_board(ld_board), .clr_start(clr_start),
      .busy(busy), .clr_done(clr_done), .board_out(board_out), .empty_cnt(empty_cnt)
   );

   board_field_writer #(.CELL_W(5)) dut5 (
      .clk(clk), .rst(rst5), .wr_valid(wr_valid5), .wr_ready(wr_ready5), .wr_pos(wr_pos5),
      .wr_val(wr_val5), .ld_valid(ld_valid5), .ld_board(ld_board5), .clr_start(clr_start5),
      .busy(busy5), .clr_done(clr_done5), .board_out(board_out5), .empty_cnt(empty_cnt5)
   );

   // ---------------- scoreboard ----------------
   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // ---------------- reference model (cell array) ----------------
   int m_cells[16];
   bit m_clearing;
   int m_next_zero;
   bit m_done;

   function automatic logic [63:0] model_board();
      logic [63:0] b;
      for (int i = 0; i < 16; i++) b[i*4 +: 4] = m_cells[i][3:0];
      return b;
   endfunction

   function automatic int model_empty();
      int n = 0;
      for (int i = 0; i < 16; i++) if (m_cells[i] == 0) n++;
      return n;
   endfunction

   task automatic model_edge();
      if (rst) begin
         foreach (m_cells[i]) m_cells[i] = 0;
         m_clearing = 0; m_next_zero = 0; m_done = 0;
      end else if (!m_clearing) begin
         m_done = 0;
         if (ld_valid) for (int i = 0; i < 16; i++) m_cells[i] = int'(ld_board[i*4 +: 4]);
         if (wr_valid) m_cells[wr_pos] = int'(wr_val);
         if (clr_start) begin m_clearing = 1; m_next_zero = 0; end
      end else begin
         m_cells[m_next_zero] = 0;
         m_next_zero++;
         m_done = (m_next_zero == 16);
         if (m_done) m_clearing = 0;
      end
   endtask

   task automatic compare_all(input string tag);
      check({tag, ".board"}, 128'(board_out), 128'(model_board()));
      check({tag, ".empty"}, 128'(empty_cnt), 128'(model_empty()));
      check({tag, ".ready"}, 128'(wr_ready),  128'(!m_clearing));
      check({tag, ".busy"},  128'(busy),      128'(m_clearing));
      check({tag, ".done"},  128'(clr_done),  128'(m_done));
   endtask

   // ---------------- driver ----------------
   task automatic drive(input logic r, input logic wv, input logic [3:0] wp, input logic [3:0] wvl,
                        input logic lv, input logic [63:0] lb, input logic cs, input string tag);
      rst = r; wr_valid = wv; wr_pos = wp; wr_val = wvl;
      ld_valid = lv; ld_board = lb; clr_start = cs;
      @(posedge clk);
      model_edge();
      #1;
      compare_all(tag);
   endtask

   task automatic idle(input string tag);
      drive(1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 64'd0, 1'b0, tag);
   endtask

   function automatic logic [63:0] rand_board();
      logic [63:0] b;
      for (int i = 0; i < 16; i++)
         b[i*4 +: 4] = ($urandom_range(0, 9) < 3) ? 4'd0 : 4'($urandom_range(1, 15));
      return b;
   endfunction

   function automatic logic [4:0] sel5(input logic [79:0] b, input int pos);
      return b[pos*5 +: 5];
   endfunction

   // ---------------- test sequence ----------------
   initial begin
      int busy_cycles, done_pulses;
      logic [63:0] full;

      rst5 = 1'b1; wr_valid5 = 0; wr_pos5 = 0; wr_val5 = 0;
      ld_valid5 = 0; ld_board5 = '0; clr_start5 = 0;

      // Reset state
      drive(1'b1, 1'b0, 4'd0, 4'd0, 1'b0, 64'd0, 1'b0, "reset");
      drive(1'b1, 1'b0, 4'd0, 4'd0, 1'b0, 64'd0, 1'b0, "reset2");
      check("rst_board", 128'(board_out), 128'd0);
      check("rst_empty", 128'(empty_cnt), 128'd16);
      check("rst_ready", 128'(wr_ready),  128'd1);
      check("rst_busy",  128'(busy),      128'd0);
      check("rst_done",  128'(clr_done),  128'd0);

      // Single write pos 5 val 3
      drive(1'b0, 1'b1, 4'd5, 4'd3, 1'b0, 64'd0, 1'b0, "wr5");
      check("wr5_board", 128'(board_out), 128'h0000_0000_0030_0000);
      check("wr5_empty", 128'(empty_cnt), 128'd15);

      // Load with same-cycle write override
      drive(1'b0, 1'b1, 4'd0, 4'd4, 1'b1, 64'h1111_2222_3333_0000, 1'b0, "ldwr");
      check("ldwr_board", 128'(board_out), 128'h1111_2222_3333_0004);
      check("ldwr_empty", 128'(empty_cnt), 128'd3);

      // Clear from a full board, with writes attempted during the clear
      full = 64'hFEDC_BA98_7654_321F;
      drive(1'b0, 1'b0, 4'd0, 4'd0, 1'b1, full, 1'b0, "full");
      check("full_empty", 128'(empty_cnt), 128'd0);
      drive(1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 64'd0, 1'b1, "clr_go");
      busy_cycles = 0; done_pulses = 0;
      if (busy) busy_cycles++;
      for (int i = 0; i < 20; i++) begin
         drive(1'b0, (i < 15), 4'($urandom_range(0, 15)), 4'($urandom_range(1, 15)),
               1'b0, 64'd0, 1'b0, "clr");
         if (busy) busy_cycles++;
         if (clr_done) begin
            done_pulses++;
            check("clr_done_board", 128'(board_out), 128'd0);
            check("clr_done_empty", 128'(empty_cnt), 128'd16);
            check("clr_done_ready", 128'(wr_ready),  128'd1);
         end
      end
      check("clr_busy_cycles", 128'(busy_cycles), 128'd16);
      check("clr_done_pulses", 128'(done_pulses), 128'd1);

      // Reset in the middle of a clear
      drive(1'b0, 1'b0, 4'd0, 4'd0, 1'b1, full, 1'b0, "full2");
      drive(1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 64'd0, 1'b1, "clr2_go");
      for (int i = 0; i < 7; i++) idle("clr2");
      drive(1'b1, 1'b0, 4'd0, 4'd0, 1'b0, 64'd0, 1'b0, "midrst");
      check("midrst_board", 128'(board_out), 128'd0);
      check("midrst_busy",  128'(busy),      128'd0);
      done_pulses = 0;
      for (int i = 0; i < 12; i++) begin
         idle("postrst");
         if (clr_done) done_pulses++;
      end
      check("midrst_no_done", 128'(done_pulses), 128'd0);
      drive(1'b0, 1'b1, 4'd9, 4'd7, 1'b0, 64'd0, 1'b0, "postrst_wr");
      check("postrst_wr_board", 128'(board_out), 128'h0000_0070_0000_0000);

      // Random traffic
      for (int i = 0; i < 600; i++) begin
         drive(($urandom_range(0, 99) < 2),
               ($urandom_range(0, 1) == 1),
               4'($urandom_range(0, 15)),
               4'($urandom_range(0, 15)),
               ($urandom_range(0, 99) < 8),
               rand_board(),
               ($urandom_range(0, 99) < 4),
               "rand");
      end

      // CELL_W=5 instance
      @(posedge clk); #1;
      rst5 = 1'b0; wr_valid5 = 1'b1; wr_pos5 = 4'd15; wr_val5 = 5'd17;
      @(posedge clk); #1;
      wr_valid5 = 1'b0;
      check("w5_field",  128'(board_out5[79:75]), 128'd17);
      check("w5_sel",    128'(sel5(board_out5, 15)), 128'd17);
      check("w5_rest",   128'(board_out5[74:0]), 128'd0);
      check("w5_empty",  128'(empty_cnt5), 128'd15);
      check("w5_ready",  128'(wr_ready5), 128'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
